sram_slot_arbiter: RTL and testbench

//  Time-slot scheduler for the shared 512K SRAM port. Drives whichturn (1 = ASIC video

---
 rtl/sram_slot_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sram_slot_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_slot_arbiter
// Description : Time-slot scheduler for the shared 512K SRAM port. A free
//               running slot counter marks video slots; the loader (before
//               rom_initialised) or the Z80 (after) is granted only when the
//               whole run of slots it needs is free of video, so an access in
//               flight is never preempted.
// Ports       : clk, rst_n            clock, async active-low reset
//               vid_active            video fetch region active
//               whichturn             1 = video owns SRAM this cycle
//               cpu_mreq_n/rfsh_n     Z80 request; refresh is never served
//               cpu_wait_n            Z80 WAIT (low = stretch)
//               ldr_req/addr/data     loader write request
//               ldr_ack, ldr_done     byte written pulse / image done pulse
//               romwrite_wr/addr/data write strobe and registered address/data
//               rom_initialised       sticky, set once the image is complete
//               cpu_wait_count        stall-cycle counter
// Options     : SRAM_ARB_STATS_EN     enables the saturating stall counter;
//                                     otherwise cpu_wait_count is 0
// Revision    : 1.0  initial release
// ============================================================================
module sram_slot_arbiter #(
  parameter int                         SLOT_BITS  = 3,
  parameter logic [(2**SLOT_BITS)-1:0]  VIDEO_MASK = 8'b01010101,
  parameter int                         CPU_HOLD   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_active,
  output logic        whichturn,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rfsh_n,
  output logic        cpu_wait_n,
  input  logic        ldr_req,
  input  logic [18:0] ldr_addr,
  input  logic [7:0]  ldr_data,
  output logic        ldr_ack,
  input  logic        ldr_done,
  output logic        romwrite_wr,
  output logic [18:0] romwrite_addr,
  output logic [7:0]  romwrite_data,
  output logic        rom_initialised,
  output logic [15:0] cpu_wait_count
);

  localparam int                   c_nslots    = 2**SLOT_BITS;
  localparam logic [SLOT_BITS-1:0] c_slot_one  = SLOT_BITS'(1);
  localparam logic [SLOT_BITS-1:0] c_hold_last = SLOT_BITS'(CPU_HOLD - 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_lwr1  = 3'd1;
  localparam logic [2:0] c_st_lwr2  = 3'd2;
  localparam logic [2:0] c_st_lack  = 3'd3;
  localparam logic [2:0] c_st_lwait = 3'd4;
  localparam logic [2:0] c_st_cpu   = 3'd5;
  localparam logic [2:0] c_st_cdone = 3'd6;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [SLOT_BITS-1:0] r_slot;
  logic [SLOT_BITS-1:0] w_slot_next;
  logic [SLOT_BITS-1:0] r_hold_cnt;
  logic                 r_whichturn;
  logic                 r_rom_init;
  logic                 r_done_pend;
  logic [18:0]          r_addr;
  logic [7:0]           r_data;
  logic                 w_cpu_acc;
  logic                 w_ldr_grant;
  logic                 w_cpu_grant;
  logic                 w_in_cpu;
  logic                 w_wr;
  logic                 w_ack;
  logic                 w_stall;

  // True when the n slots starting at 'start' (with wrap) hold no video slot.
  function automatic logic free_run(input logic [SLOT_BITS-1:0] start,
                                    input int n, input logic active);
    logic                 ok;
    logic [SLOT_BITS-1:0] idx;
    ok = 1'b1;
    for (int k = 0; k < c_nslots; k++) begin
      idx = start + SLOT_BITS'(k);
      if ((k < n) && VIDEO_MASK[idx] && active) ok = 1'b0;
    end
    return ok;
  endfunction

  assign w_cpu_acc   = !cpu_mreq_n && cpu_rfsh_n;
  assign w_slot_next = r_slot + c_slot_one;
  assign w_ldr_grant = (r_state == c_st_idle) && !r_rom_init && ldr_req &&
                       free_run(r_slot, 2, vid_active);
  // Loader grant already requires !rom_initialised, so the two are exclusive.
  assign w_cpu_grant = (r_state == c_st_idle) && r_rom_init && w_cpu_acc &&
                       free_run(r_slot, CPU_HOLD, vid_active);

  // An access granted in this very cycle is not stretched, so a free port
  // never costs the Z80 a wait state.
  assign w_stall     = w_cpu_acc && !w_in_cpu && !w_cpu_grant;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_ldr_grant)      w_state_next = c_st_lwr1;
        else if (w_cpu_grant) w_state_next = c_st_cpu;
      end
      c_st_lwr1:  w_state_next = c_st_lwr2;
      c_st_lwr2:  w_state_next = c_st_lack;
      c_st_lack:  w_state_next = c_st_lwait;
      // One write per request: wait for the request to drop before re-arming.
      c_st_lwait: if (!ldr_req) w_state_next = c_st_idle;
      c_st_cpu:   if (r_hold_cnt == c_hold_last) w_state_next = c_st_cdone;
      c_st_cdone: if (cpu_mreq_n) w_state_next = c_st_idle;
      default:    w_state_next = c_st_idle;
    endcase
  end

  // Output decode
  always_comb begin
    w_wr     = 1'b0;
    w_ack    = 1'b0;
    w_in_cpu = 1'b0;
    case (r_state)
      c_st_lwr1, c_st_lwr2: w_wr     = 1'b1;
      c_st_lack:            w_ack    = 1'b1;
      c_st_cpu, c_st_cdone: w_in_cpu = 1'b1;
      default: ;
    endcase
  end

  // Slot counter, video turn, hold counter and loader data latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= '0;
      r_whichturn <= 1'b0;
      r_hold_cnt  <= '0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_slot      <= w_slot_next;
      r_whichturn <= VIDEO_MASK[w_slot_next] & vid_active;
      if (w_cpu_grant)               r_hold_cnt <= '0;
      else if (r_state == c_st_cpu)  r_hold_cnt <= r_hold_cnt + c_slot_one;
      if (w_ldr_grant) begin
        r_addr <= ldr_addr;
        r_data <= ldr_data;
      end
    end
  end

  // Image-complete flag. A done pulse arriving during a write is held back
  // until the ack has gone out, so the final byte is acknowledged first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_init  <= 1'b0;
      r_done_pend <= 1'b0;
    end else begin
      case (r_state)
        c_st_lwr1, c_st_lwr2: if (ldr_done) r_done_pend <= 1'b1;
        c_st_lack: begin
          if (r_done_pend || ldr_done) r_rom_init <= 1'b1;
          r_done_pend <= 1'b0;
        end
        default: if (ldr_done) r_rom_init <= 1'b1;
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_wait_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_wait_count <= 16'h0000;
    else if (w_stall && r_wait_count != 16'hFFFF) r_wait_count <= r_wait_count + 16'h0001;
  end

  assign cpu_wait_count = r_wait_count;
`else
  assign cpu_wait_count = 16'h0000;
`endif

  assign whichturn       = r_whichturn;
  assign cpu_wait_n      = !w_stall;
  assign ldr_ack         = w_ack;
  assign romwrite_wr     = w_wr;
  assign romwrite_addr   = r_addr;
  assign romwrite_data   = r_data;
  assign rom_initialised = r_rom_init;

endmodule
`default_nettype wire

// File: tb/tb_sram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_slot_arbiter
// Description : Self-checking bench for sram_slot_arbiter. Stimulus pushes
//               expected loader writes and CPU stall lengths into queues; a
//               negedge monitor pops and compares when the DUT shows a write
//               or a CPU access, and checks the video turn every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_slot_arbiter;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_active = 1'b1;
  logic        whichturn;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_rfsh_n = 1'b1;
  logic        cpu_wait_n;
  logic        ldr_req = 1'b0;
  logic [18:0] ldr_addr = '0;
  logic [7:0]  ldr_data = '0;
  logic        ldr_ack;
  logic        ldr_done = 1'b0;
  logic        romwrite_wr;
  logic [18:0] romwrite_addr;
  logic [7:0]  romwrite_data;
  logic        rom_initialised;
  logic [15:0] cpu_wait_count;

  sram_slot_arbiter dut (
    .clk(clk), .rst_n(rst_n), .vid_active(vid_active), .whichturn(whichturn),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rfsh_n(cpu_rfsh_n), .cpu_wait_n(cpu_wait_n),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
    .ldr_ack(ldr_ack), .ldr_done(ldr_done), .romwrite_wr(romwrite_wr),
    .romwrite_addr(romwrite_addr), .romwrite_data(romwrite_data),
    .rom_initialised(rom_initialised), .cpu_wait_count(cpu_wait_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [18:0] addr; logic [7:0] data; int cyc; } wexp_t;
  wexp_t      wq[$];
  int         cq[$];
  logic [7:0] mask_v = 8'b01010101;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       va_s = 1'b0;
  int         exp_stalls = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference time base: posedges since reset release and vid_active seen there.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= 0;
      va_s <= 1'b0;
    end else begin
      cyc  <= cyc + 1;
      va_s <= vid_active;
    end
  end

  // First cycle >= start whose slot begins a video-free run of n slots.
  function automatic int first_free(input int start, input int n, input logic va);
    logic ok;
    for (int j = start; j < start + 8; j++) begin
      ok = 1'b1;
      for (int k = 0; k < n; k++) if (mask_v[(j + k) % 8] && va) ok = 1'b0;
      if (ok) return j;
    end
    return -1;
  endfunction

  // Monitor
  initial begin
    logic  wr_prev, in_acc, popped;
    int    wr_len, wr_start, stall;
    wexp_t e;
    wr_prev = 1'b0; in_acc = 1'b0; popped = 1'b0;
    wr_len = 0; wr_start = -1000; stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_prev = 1'b0; in_acc = 1'b0; popped = 1'b0;
        wr_len = 0; wr_start = -1000; stall = 0;
      end else begin
        chk("whichturn", whichturn, (cyc == 0) ? 0 : int'(mask_v[cyc % 8] & va_s));
        // Loader writes
        if (romwrite_wr) begin
          chk("wr_vs_video", whichturn, 0);
          if (!wr_prev) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
              e = wq.pop_front();
              chk("wr_addr", romwrite_addr, e.addr);
              chk("wr_data", romwrite_data, e.data);
              chk("wr_cycle", cyc, e.cyc);
            end
            wr_len = 1;
            wr_start = cyc;
          end else wr_len++;
        end else if (wr_prev) chk("wr_len", wr_len, 2);
        wr_prev = romwrite_wr;
        if (ldr_ack) begin
          chk("ack_timing", cyc - wr_start, 2);
          wr_start = -1000;
        end
        // CPU accesses
        if (!cpu_mreq_n && cpu_rfsh_n) begin
          if (!popped) begin
            if (!cpu_wait_n) stall++;
            else begin
              if (cq.size() == 0) chk("unexpected_cpu", 1, 0);
              else chk("cpu_stall", stall, cq.pop_front());
              popped = 1'b1;
            end
          end else if (!cpu_wait_n) chk("wait_after_grant", 0, 1);
          in_acc = 1'b1;
        end else begin
          if (in_acc && !popped) begin
            if (cq.size() == 0) chk("unexpected_cpu", 1, 0);
            else chk("cpu_stall", stall, cq.pop_front());
          end
          in_acc = 1'b0; popped = 1'b0; stall = 0;
        end
      end
    end
  end

  task automatic wait_ack();
    int n;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ldr_ack) break;
    end
    chk("ack_seen", ldr_ack, 1);
  endtask

  // Called just after a posedge with the FSM idle.
  task automatic do_write(input logic [18:0] a, input logic [7:0] d,
                          input logic va, input int k, input int hold_after);
    int j;
    vid_active = va; ldr_addr = a; ldr_data = d; ldr_req = 1'b1;
    j = first_free(cyc, 2, va);
    if (j < 0) begin
      repeat (k) @(posedge clk);
      #1 vid_active = 1'b0;
      j = first_free(cyc, 2, 1'b0);
    end
    wq.push_back('{a, d, j + 1});
    wait_ack();
    repeat (hold_after) @(posedge clk);
    #1 ldr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_cpu(input logic va, input int k, input int h, input logic flip);
    int j;
    vid_active = va; cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b1;
    j = first_free(cyc, HOLD, va);
    if (j >= 0) begin
      cq.push_back(j - cyc);
      exp_stalls += j - cyc;
    end else begin
      cq.push_back(k);
      exp_stalls += k;
      repeat (k) @(posedge clk);
      #1 vid_active = 1'b0;
    end
    for (int i = 0; i < h; i++) begin
      @(posedge clk);
      #1 if (flip && i == 0) vid_active = 1'b1;
    end
    cpu_mreq_n = 1'b1;
    repeat (HOLD + 2 + int'($urandom_range(0, 2))) @(posedge clk);
    #1;
  endtask

  function automatic int exp_count();
`ifdef SRAM_ARB_STATS_EN
    return (exp_stalls > 65535) ? 65535 : exp_stalls;
`else
    return 0;
`endif
  endfunction

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_whichturn", whichturn, 0);
    chk("rst_wait_n", cpu_wait_n, 1);
    chk("rst_ack", ldr_ack, 0);
    chk("rst_wr", romwrite_wr, 0);
    chk("rst_addr", romwrite_addr, 0);
    chk("rst_data", romwrite_data, 0);
    chk("rst_rom_init", rom_initialised, 0);
    chk("rst_count", cpu_wait_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // CPU access before the image is loaded stalls even on free slots.
    vid_active = 1'b0; cpu_mreq_n = 1'b0;
    cq.push_back(12);
    exp_stalls += 12;
    repeat (12) @(posedge clk);
    #1 cpu_mreq_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 vid_active = 1'b1;

    // Loader request on a video slot: no grant while video owns every pair.
    for (int i = 0; i < 8; i++) begin
      if (cyc % 8 == 1) break;
      @(posedge clk);
      #1;
    end
    do_write(19'h40000, 8'hA5, 1'b1, 20, 10);
    chk("rom_init_early", rom_initialised, 0);

    for (int i = 0; i < 5; i++)
      do_write(19'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 5), $urandom_range(1, 4));

    // Image completes during the second write cycle.
    vid_active = 1'b0; ldr_addr = 19'h7FFFF; ldr_data = 8'h3C; ldr_req = 1'b1;
    wq.push_back('{19'h7FFFF, 8'h3C, cyc + 1});
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (romwrite_wr) break;
    end
    chk("last_wr_seen", romwrite_wr, 1);
    @(posedge clk);
    #1 ldr_done = 1'b1;
    @(posedge clk);
    #1 ldr_done = 1'b0;
    @(negedge clk);
    chk("done_ack", ldr_ack, 1);
    chk("done_rom_init_at_ack", rom_initialised, 0);
    @(negedge clk);
    chk("done_rom_init_lwait", rom_initialised, 1);
    @(posedge clk);
    #1 ldr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Loader requests after the image is complete are ignored.
    ldr_req = 1'b1;
    repeat (10) @(posedge clk);
    #1 ldr_req = 1'b0;

    for (int i = 0; i < 25; i++)
      do_cpu(1'($urandom_range(0, 1)), $urandom_range(1, 6),
             $urandom_range(1, 5), 1'($urandom_range(0, 1)));

    // Refresh is neither stalled nor served; a following access still waits.
    vid_active = 1'b0; cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rfsh_wait_n", cpu_wait_n, 1);
    end
    @(posedge clk);
    #1 do_cpu(1'b1, 3, 3, 1'b0);
    chk("wait_count", cpu_wait_count, exp_count());

    // Asynchronous reset while the CPU owns the port.
    vid_active = 1'b0; cpu_mreq_n = 1'b0;
    cq.push_back(0);
    @(posedge clk);
    #1 rst_n = 1'b0; cpu_mreq_n = 1'b1;
    #1;
    chk("arst_whichturn", whichturn, 0);
    chk("arst_rom_init", rom_initialised, 0);
    chk("arst_addr", romwrite_addr, 0);
    chk("arst_count", cpu_wait_count, 0);
    chk("arst_wait_n", cpu_wait_n, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; vid_active = 1'b1;
    repeat (16) @(posedge clk);
    #1 do_write(19'h00123, 8'h5A, 1'b0, 0, 1);

    repeat (4) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("cq_empty", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
